// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a self-initialising fill sequence, bit-masked
// write-first writes, registered read data and a sticky out-of-range error flag.
module data_mem_responder #(
  parameter int unsigned DEPTH    = 1024,
  parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DM_WEB,
  input  logic [31:0] DM_BWEB,
  input  logic [13:0] DM_A,
  input  logic [31:0] DM_IN,
  output logic [31:0] DM_OUT,
  output logic        ready,
  output logic        oor_err,
  input  logic        clr_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {StInit, StRun} state_e;

  state_e          state_q;
  logic [AW-1:0]   cnt_q;
  logic [31:0]     mem [DEPTH];

  logic            in_range;
  logic [AW-1:0]   idx;
  logic [31:0]     old_word;
  logic [31:0]     merged;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [31:0]     mem_wdata;

  // Full 14-bit compare so addresses beyond DEPTH never alias onto low words.
  assign in_range = 32'(DM_A) < DEPTH;
  assign idx      = DM_A[AW-1:0];
  assign old_word = mem[idx];
  assign merged   = (old_word & DM_BWEB) | (DM_IN & ~DM_BWEB);

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = cnt_q;
    mem_wdata = INIT_VAL;
    if (state_q == StInit) begin
      mem_we = 1'b1;
    end else if (!DM_WEB && in_range) begin
      mem_we    = 1'b1;
      mem_addr  = idx;
      mem_wdata = merged;
    end
  end

  // Storage has no reset; the init sequence rewrites every word after release.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StInit;
      cnt_q   <= '0;
      DM_OUT  <= '0;
      ready   <= 1'b0;
      oor_err <= 1'b0;
    end else begin
      unique case (state_q)
        StInit: begin
          DM_OUT <= '0;
          if (cnt_q == AW'(DEPTH - 1)) begin
            state_q <= StRun;
            ready   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRun: begin
          if (!in_range) begin
            DM_OUT  <= '0;
            oor_err <= 1'b1;
          end else begin
            if (clr_err) begin
              oor_err <= 1'b0;
            end
            // Write-first: a write returns the merged word on the same edge.
            DM_OUT <= DM_WEB ? old_word : merged;
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder with DEPTH=16.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        DM_WEB;
  logic [31:0] DM_BWEB;
  logic [13:0] DM_A;
  logic [31:0] DM_IN;
  logic [31:0] DM_OUT;
  logic        ready;
  logic        oor_err;
  logic        clr_err;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_responder #(
    .DEPTH   (16),
    .INIT_VAL(32'h0000_0000)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .DM_WEB (DM_WEB),
    .DM_BWEB(DM_BWEB),
    .DM_A   (DM_A),
    .DM_IN  (DM_IN),
    .DM_OUT (DM_OUT),
    .ready  (ready),
    .oor_err(oor_err),
    .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one access and sample 1 time unit after the capturing edge.
  task automatic access(input logic web, input logic [31:0] bweb, input logic [13:0] a,
                        input logic [31:0] din, input logic clr);
    DM_WEB  = web;
    DM_BWEB = bweb;
    DM_A    = a;
    DM_IN   = din;
    clr_err = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b0;
    DM_WEB  = 1'b1;
    DM_BWEB = '1;
    DM_A    = '0;
    DM_IN   = '0;
    clr_err = 1'b0;
    #2;
    check("reset_dout", DM_OUT, 32'h0);
    check("reset_ready", {31'b0, ready}, 32'h0);
    check("reset_oor", {31'b0, oor_err}, 32'h0);

    @(posedge clk);
    #1;
    rst = 1'b1;
    // Hostile traffic during init must be ignored.
    DM_WEB  = 1'b0;
    DM_BWEB = '0;
    DM_A    = 14'd2;
    DM_IN   = 32'hFFFF_FFFF;
    for (int i = 1; i <= 16; i++) begin
      if (i == 8) DM_A = 14'd20;
      @(posedge clk);
      #1;
      if (i == 8) check("init_dout_held", DM_OUT, 32'h0);
      if (i == 15) check("init_ready_low", {31'b0, ready}, 32'h0);
      if (i == 16) check("init_ready_high", {31'b0, ready}, 32'h1);
    end
    check("init_oor_ignored", {31'b0, oor_err}, 32'h0);

    for (int i = 0; i < 16; i++) begin
      access(1'b1, '1, 14'(i), 32'h0, 1'b0);
      check($sformatf("init_word%0d", i), DM_OUT, 32'h0);
    end

    access(1'b0, 32'h0, 14'd3, 32'hDEAD_BEEF, 1'b0);
    check("wr3_first", DM_OUT, 32'hDEAD_BEEF);
    access(1'b1, '1, 14'd3, 32'h0, 1'b0);
    check("rd3", DM_OUT, 32'hDEAD_BEEF);

    access(1'b0, 32'hFFFF_00FF, 14'd3, 32'h1234_5678, 1'b0);
    check("wr3_mask", DM_OUT, 32'hDEAD_56EF);
    access(1'b1, '1, 14'd3, 32'h0, 1'b0);
    check("rd3_mask", DM_OUT, 32'hDEAD_56EF);

    access(1'b0, 32'hFFFF_FFFF, 14'd3, 32'h0, 1'b0);
    check("wr3_nomask", DM_OUT, 32'hDEAD_56EF);
    access(1'b1, '1, 14'd3, 32'h0, 1'b0);
    check("rd3_nomask", DM_OUT, 32'hDEAD_56EF);

    access(1'b0, 32'h0, 14'd16, 32'h1, 1'b0);
    check("oor_dout", DM_OUT, 32'h0);
    check("oor_set", {31'b0, oor_err}, 32'h1);
    access(1'b1, '1, 14'd0, 32'h0, 1'b0);
    check("oor_word0", DM_OUT, 32'h0);
    check("oor_sticky", {31'b0, oor_err}, 32'h1);

    // High address bits must be decoded, not dropped.
    access(1'b0, 32'h0, 14'h2003, 32'h0, 1'b0);
    check("nowrap_dout", DM_OUT, 32'h0);
    access(1'b1, '1, 14'd3, 32'h0, 1'b0);
    check("nowrap_word3", DM_OUT, 32'hDEAD_56EF);

    access(1'b1, '1, 14'd20, 32'h0, 1'b1);
    check("clr_vs_set", {31'b0, oor_err}, 32'h1);
    access(1'b1, '1, 14'd3, 32'h0, 1'b1);
    check("clr_alone", {31'b0, oor_err}, 32'h0);
    access(1'b1, '1, 14'd3, 32'h0, 1'b0);
    check("clr_stays", {31'b0, oor_err}, 32'h0);

    access(1'b0, 32'h0, 14'd7, 32'h1, 1'b0);
    check("b2b_1", DM_OUT, 32'h1);
    access(1'b0, 32'h0, 14'd7, 32'h2, 1'b0);
    check("b2b_2", DM_OUT, 32'h2);
    access(1'b1, '1, 14'd7, 32'h0, 1'b0);
    check("b2b_rd", DM_OUT, 32'h2);

    access(1'b0, 32'h0, 14'd5, 32'hA5A5_A5A5, 1'b0);
    check("wr5", DM_OUT, 32'hA5A5_A5A5);
    check("run_ready", {31'b0, ready}, 32'h1);

    DM_WEB = 1'b1;
    DM_A   = 14'd16;
    #2;
    rst = 1'b0;
    #1;
    check("rst_async_dout", DM_OUT, 32'h0);
    check("rst_async_ready", {31'b0, ready}, 32'h0);
    check("rst_async_oor", {31'b0, oor_err}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      if (i == 15) check("reinit_ready_low", {31'b0, ready}, 32'h0);
      if (i == 16) check("reinit_ready_high", {31'b0, ready}, 32'h1);
    end
    check("reinit_oor", {31'b0, oor_err}, 32'h0);
    access(1'b1, '1, 14'd5, 32'h0, 1'b0);
    check("reinit_word5", DM_OUT, 32'h0);
    access(1'b1, '1, 14'd7, 32'h0, 1'b0);
    check("reinit_word7", DM_OUT, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 1024: number of 32-bit words stored; power of two, 16 to 16384.
REQ-002 Parameter INIT_VAL, default 32'h0000_0000: value written to every word by the init sequence.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 DM_WEB  input  1  write enable, active-low; 0 = write cycle, 1 = read cycle.
REQ-006 DM_BWEB  input  32  per-bit write mask, active-low; bit i = 0 writes bit i.
REQ-007 DM_A  input  14  word address.
REQ-008 DM_IN  input  32  write data.
REQ-009 DM_OUT  output  32  registered read data.
REQ-010 ready  output  1  high when init is complete and accesses are serviced.
REQ-011 oor_err  output  1  sticky flag for an out-of-range access.
REQ-012 clr_err  input  1  synchronous clear of oor_err, active-high.

Function
REQ-013 The FSM SHALL have two states: INIT and RUN.
REQ-014 INIT SHALL hold a word counter starting at 0, write INIT_VAL to word[counter] each cycle, and increment the counter.
REQ-015 When counter = DEPTH-1 is written, the FSM SHALL move to RUN on the same edge; ready rises on that edge (DEPTH cycles after rst release).
REQ-016 In INIT, the block SHALL ignore DM_WEB/DM_BWEB/DM_A/DM_IN, hold DM_OUT at 0 and hold ready at 0.
REQ-017 RUN SHALL be left only by reset.
REQ-018 In RUN every cycle is an access: DM_WEB=1 is a read, DM_WEB=0 is a write.
REQ-019 Read SHALL give DM_OUT = word[DM_A] on the next rising edge (1-cycle latency); DM_OUT holds between edges.
REQ-020 Write SHALL update word[DM_A] bit i to DM_IN[i] where DM_BWEB[i]=0, and keep the old bit where DM_BWEB[i]=1.
REQ-021 Write SHALL be write-first: on the same edge DM_OUT = the merged new word.
REQ-022 Write with DM_BWEB = all ones SHALL leave memory unchanged and give DM_OUT = the old word.
REQ-023 Read one cycle after a write to the same address SHALL return the written data (no stale data).
REQ-024 Out-of-range access (DM_A >= DEPTH) SHALL discard the write, set DM_OUT = 0 on the next edge, and set oor_err = 1.
REQ-025 oor_err SHALL stay 1 until clr_err = 1 at an edge.
REQ-026 If clr_err and a new out-of-range access fall in the same cycle, set wins and oor_err stays 1.
REQ-027 Out-of-range accesses in INIT SHALL NOT set oor_err.
REQ-028 Addresses SHALL NOT wrap; DM_A bits above log2(DEPTH) are decoded, not truncated.

Reset
REQ-029 While rst = 0: state = INIT, counter = 0, DM_OUT = 0, ready = 0, oor_err = 0, all asynchronously.
REQ-030 Memory contents are not reset directly; they are rewritten by the init sequence after rst = 1.
REQ-031 Reset asserted mid-INIT or mid-RUN SHALL abort any access in progress and restart init from word 0 after release.

Verification
REQ-032 DEPTH=16: release rst -> ready = 0 for 16 edges, 1 after the 16th; reads of words 0..15 return 0.
REQ-033 Write A=3, DM_IN=32'hDEADBEEF, BWEB=0 -> DM_OUT=DEADBEEF that edge; read A=3 next cycle -> DEADBEEF.
REQ-034 A=3 holds 32'hDEADBEEF; write DM_IN=32'h12345678, BWEB=32'hFFFF00FF -> word becomes 32'hDEAD56EF.
REQ-035 DEPTH=16: write A=16, DM_IN=1 -> DM_OUT=0, oor_err=1, word 0 unchanged.
REQ-035 (cont.) clr_err with a new out-of-range access -> oor_err stays 1; clr_err alone -> 0.
REQ-036 Assert rst mid-RUN after writing A=5=32'hA5A5A5A5 -> outputs 0 at once; after re-init, read A=5 -> INIT_VAL.
REQ-037 Back-to-back writes to A=7 (32'h1, then 32'h2) followed by a read -> DM_OUT sequence 1, 2, 2.
